// File: rtl/udp_tx.sv
// rtl/udp_tx.sv - UDP transmit framer: prepends the 8-byte UDP header to a byte-wide payload stream.
// Optional store-and-forward checksum generation is enabled by defining UDP_TX_CHECKSUM_EN.
module udp_tx #(
    parameter int MAX_PAYLOAD = 1472
) (
    input  logic        tx_mac_aclk,
    input  logic        tx_mac_reset,
    input  logic [15:0] tx_udp_src_port,
    input  logic [15:0] tx_udp_dst_port,
    input  logic [15:0] tx_udp_len,
    input  logic [31:0] tx_ip_src,
    input  logic [31:0] tx_ip_dst,
    input  logic [7:0]  tx_axis_udp_tdata,
    input  logic        tx_axis_udp_tvalid,
    input  logic        tx_axis_udp_tlast,
    output logic        tx_axis_udp_tready,
    output logic [7:0]  tx_axis_ip_tdata,
    output logic        tx_axis_ip_tvalid,
    output logic        tx_axis_ip_tlast,
    input  logic        tx_axis_ip_tready,
    output logic [7:0]  tx_ip_proto,
    output logic [15:0] tx_ip_len,
    output logic        tx_busy,
    output logic        tx_len_err
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HDR, S_PAYLOAD, S_DROP, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] src_q, src_d, dst_q, dst_d, len_q, len_d, len8_q, len8_d;
    logic [15:0] ip_len_q, ip_len_d, cnt_q, cnt_d;
    logic [2:0]  hdr_idx_q, hdr_idx_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic        busy_q, busy_d, err_q, err_d;

    logic        load_en, udp_accept;
    logic [15:0] cnt_n, plen_w, chk_w;
    logic [7:0]  buf_rdata;

    assign load_en    = !out_valid_q || tx_axis_ip_tready;
    assign udp_accept = tx_axis_udp_tvalid && tx_axis_udp_tready;
    assign cnt_n      = cnt_q + 16'd1;

    function automatic logic [7:0] hdr_byte(input logic [2:0] idx, input logic [15:0] src,
                                            input logic [15:0] dst, input logic [15:0] len8,
                                            input logic [15:0] chk);
        case (idx)
            3'd0:    hdr_byte = src[15:8];
            3'd1:    hdr_byte = src[7:0];
            3'd2:    hdr_byte = dst[15:8];
            3'd3:    hdr_byte = dst[7:0];
            3'd4:    hdr_byte = len8[15:8];
            3'd5:    hdr_byte = len8[7:0];
            3'd6:    hdr_byte = chk[15:8];
            default: hdr_byte = chk[7:0];
        endcase
    endfunction

`ifdef UDP_TX_CHECKSUM_EN
    localparam int AW = $clog2(MAX_PAYLOAD);
    localparam bit CSUM_EN = 1'b1;

    logic [7:0]  buf_q [0:MAX_PAYLOAD-1];
    logic [31:0] ip_src_q, ip_dst_q, acc_q, acc_d, sum_w;
    logic [15:0] nbytes_q, nbytes_d, f2_w, inv_w;
    logic [16:0] f1_w;
    logic        emit_q, emit_d;

    always_ff @(posedge tx_mac_aclk) begin
        if (state_q == S_LOAD && udp_accept)
            buf_q[cnt_q[AW-1:0]] <= tx_axis_udp_tdata;
    end

    always_ff @(posedge tx_mac_aclk) begin
        if (tx_mac_reset) begin
            ip_src_q <= 32'h0;
            ip_dst_q <= 32'h0;
            acc_q    <= 32'h0;
            nbytes_q <= 16'h0;
            emit_q   <= 1'b0;
        end else begin
            if (state_q == S_IDLE && tx_axis_udp_tvalid) begin
                ip_src_q <= tx_ip_src;
                ip_dst_q <= tx_ip_dst;
            end
            acc_q    <= acc_d;
            nbytes_q <= nbytes_d;
            emit_q   <= emit_d;
        end
    end

    // Pseudo-header plus UDP header (checksum field zero) added on top of the payload sum.
    assign sum_w = acc_q + {16'h0, ip_src_q[31:16]} + {16'h0, ip_src_q[15:0]}
                 + {16'h0, ip_dst_q[31:16]} + {16'h0, ip_dst_q[15:0]} + 32'h0000_0011
                 + {16'h0, len8_q} + {16'h0, src_q} + {16'h0, dst_q} + {16'h0, len8_q};
    assign f1_w  = {1'b0, sum_w[15:0]} + {1'b0, sum_w[31:16]};
    assign f2_w  = f1_w[15:0] + {15'h0, f1_w[16]};
    assign inv_w = ~f2_w;
    assign chk_w = (inv_w == 16'h0000) ? 16'hFFFF : inv_w;
    assign plen_w    = nbytes_q;
    assign buf_rdata = buf_q[cnt_q[AW-1:0]];
`else
    localparam bit CSUM_EN = 1'b0;
    logic unused_ok;
    assign unused_ok = ^{tx_ip_src, tx_ip_dst, 32'(MAX_PAYLOAD)};
    assign chk_w     = 16'h0000;
    assign plen_w    = len_q;
    assign buf_rdata = 8'h00;
`endif

    always_ff @(posedge tx_mac_aclk) begin
        if (tx_mac_reset) begin
            state_q     <= S_IDLE;
            src_q       <= 16'h0;
            dst_q       <= 16'h0;
            len_q       <= 16'h0;
            len8_q      <= 16'h0;
            ip_len_q    <= 16'h0;
            cnt_q       <= 16'h0;
            hdr_idx_q   <= 3'd0;
            out_data_q  <= 8'h0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            len8_q      <= len8_d;
            ip_len_q    <= ip_len_d;
            cnt_q       <= cnt_d;
            hdr_idx_q   <= hdr_idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        len_d       = len_q;
        len8_d      = len8_q;
        ip_len_d    = ip_len_q;
        cnt_d       = cnt_q;
        hdr_idx_d   = hdr_idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !tx_axis_ip_tready;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        err_d       = 1'b0;
`ifdef UDP_TX_CHECKSUM_EN
        acc_d       = acc_q;
        nbytes_d    = nbytes_q;
        emit_d      = emit_q;
`endif
        case (state_q)
            S_IDLE: if (tx_axis_udp_tvalid) begin
                src_d    = tx_udp_src_port;
                dst_d    = tx_udp_dst_port;
                len_d    = tx_udp_len;
                len8_d   = tx_udp_len + 16'd8;
                ip_len_d = tx_udp_len + 16'd8;
                busy_d   = 1'b1;
                cnt_d    = 16'h0;
`ifdef UDP_TX_CHECKSUM_EN
                acc_d     = 32'h0;
                nbytes_d  = 16'h0;
                emit_d    = 1'b1;
                hdr_idx_d = 3'd0;
                if (tx_udp_len > 16'(MAX_PAYLOAD)) begin
                    err_d   = 1'b1;
                    emit_d  = 1'b0;
                    state_d = S_DROP;
                end else if (tx_udp_len == 16'h0) begin
                    state_d = S_DROP;
                end else begin
                    state_d = S_LOAD;
                end
`else
                // The output register is always empty in IDLE, so byte 1 goes out straight away.
                out_data_d  = tx_udp_src_port[15:8];
                out_valid_d = 1'b1;
                out_last_d  = 1'b0;
                hdr_idx_d   = 3'd1;
                state_d     = S_HDR;
`endif
            end
            S_LOAD: begin
`ifdef UDP_TX_CHECKSUM_EN
                if (udp_accept) begin
                    cnt_d = cnt_n;
                    acc_d = acc_q + (cnt_q[0] ? {24'h0, tx_axis_udp_tdata}
                                              : {16'h0, tx_axis_udp_tdata, 8'h00});
                    if (cnt_n == len_q) begin
                        nbytes_d = cnt_n;
                        if (tx_axis_udp_tlast) begin
                            state_d = S_HDR;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_DROP;
                        end
                    end else if (tx_axis_udp_tlast) begin
                        nbytes_d = cnt_n;
                        err_d    = 1'b1;
                        state_d  = S_HDR;
                    end
                end
`endif
            end
            S_HDR: if (load_en) begin
                out_data_d  = hdr_byte(hdr_idx_q, src_q, dst_q, len8_q, chk_w);
                out_valid_d = 1'b1;
                out_last_d  = 1'b0;
                hdr_idx_d   = hdr_idx_q + 3'd1;
                if (hdr_idx_q == 3'd7) begin
                    cnt_d = 16'h0;
                    if (plen_w == 16'h0) begin
                        out_last_d = 1'b1;
                        state_d    = CSUM_EN ? S_DONE : S_DROP;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (CSUM_EN) begin
                    if (load_en) begin
                        out_data_d  = buf_rdata;
                        out_valid_d = 1'b1;
                        out_last_d  = (cnt_n == plen_w);
                        cnt_d       = cnt_n;
                        if (cnt_n == plen_w)
                            state_d = S_DONE;
                    end
                end else if (udp_accept) begin
                    out_data_d  = tx_axis_udp_tdata;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    cnt_d       = cnt_n;
                    if (cnt_n == len_q) begin
                        out_last_d = 1'b1;
                        if (tx_axis_udp_tlast) begin
                            state_d = S_DONE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_DROP;
                        end
                    end else if (tx_axis_udp_tlast) begin
                        out_last_d = 1'b1;
                        err_d      = 1'b1;
                        state_d    = S_DONE;
                    end
                end
            end
            S_DROP: if (tx_axis_udp_tvalid && tx_axis_udp_tlast) begin
`ifdef UDP_TX_CHECKSUM_EN
                state_d = emit_q ? S_HDR : S_DONE;
`else
                state_d = S_DONE;
`endif
            end
            S_DONE: if (!out_valid_q || tx_axis_ip_tready) begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_axis_udp_tready = 1'b0;
        case (state_q)
            S_LOAD:    tx_axis_udp_tready = 1'b1;
            S_PAYLOAD: tx_axis_udp_tready = CSUM_EN ? 1'b0 : load_en;
            S_DROP:    tx_axis_udp_tready = 1'b1;
            default:   tx_axis_udp_tready = 1'b0;
        endcase
    end

    assign tx_axis_ip_tdata  = out_data_q;
    assign tx_axis_ip_tvalid = out_valid_q;
    assign tx_axis_ip_tlast  = out_last_q;
    assign tx_ip_proto       = 8'd17;
    assign tx_ip_len         = ip_len_q;
    assign tx_busy           = busy_q;
    assign tx_len_err        = err_q;

endmodule
